// File: rtl/sin_cos_pkg.sv
// Shared types and helpers for the sin/cos core arbiter.
package sin_cos_pkg;

  // Widest requester index the arbiter supports (NREQ up to 8).
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  function automatic int id_w(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/sin_cos_rr_pick.sv
// Combinational round-robin winner search: first set request at or after ptr, wrapping.
module sin_cos_rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Two passes: the upper segment [ptr..NREQ-1] first, then the wrapped [0..ptr-1].
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any    = 1'b1;
        idx    = ID_W'(i);
        gnt[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        idx    = ID_W'(i);
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sin_cos_arb.sv
// Round-robin scheduler sharing one pipelined sin/cos core among NREQ requesters.
// Optional grant-lock behaviour is compiled in with SIN_COS_ARB_LOCK_EN.
module sin_cos_arb
  import sin_cos_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PHASE_W = 10,
  parameter int NREQ    = 4,
  parameter int LAT     = 2,
  localparam int ID_W   = id_w(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*PHASE_W-1:0]  req_phase,
  input  logic [NREQ-1:0]          req_lock,
  output logic [NREQ-1:0]          req_ready,
  output logic [PHASE_W-1:0]       core_phase,
  output logic                     core_valid,
  input  logic [WIDTH-1:0]         core_sin,
  input  logic [WIDTH-1:0]         core_cos,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sin,
  output logic [WIDTH-1:0]         rsp_cos,
  output logic                     busy
);

  logic [NREQ-1:0]               cand;
  logic [NREQ-1:0]               gnt;
  logic [ID_W-1:0]               ptr, ptr_nxt, gidx;
  logic                          gany, hold;
  logic [NREQ-1:0][PHASE_W-1:0]  phase_arr;
  tag_t [LAT:0]                  tag_pipe;
  tag_t                          tag_in;

  assign cand      = req_valid & {NREQ{en}};
  assign phase_arr = req_phase;
  assign req_ready = gnt;

  sin_cos_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req (cand),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

`ifdef SIN_COS_ARB_LOCK_EN
  assign hold = req_lock[gidx];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign hold        = 1'b0;
`endif

  always_comb begin
    ptr_nxt = ptr;
    if (gany) begin
      if (hold)                          ptr_nxt = gidx;
      else if (gidx == ID_W'(NREQ - 1))  ptr_nxt = '0;
      else                               ptr_nxt = gidx + ID_W'(1);
    end
  end

  assign tag_in = '{valid: gany, id: MAX_ID_W'(gidx)};

  // One extra stage beyond LAT: the core samples core_valid one edge after issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      tag_pipe   <= '0;
      core_valid <= 1'b0;
      core_phase <= '0;
    end else begin
      ptr        <= ptr_nxt;
      tag_pipe   <= {tag_pipe[LAT-1:0], tag_in};
      core_valid <= gany;
      if (gany) core_phase <= phase_arr[gidx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sin   <= '0;
      rsp_cos   <= '0;
    end else if (tag_pipe[LAT].valid) begin
      rsp_valid <= 1'b1;
      rsp_id    <= tag_pipe[LAT].id[ID_W-1:0];
      rsp_sin   <= core_sin;
      rsp_cos   <= core_cos;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  always_comb begin
    busy = rsp_valid;
    for (int k = 0; k <= LAT; k++) busy = busy | tag_pipe[k].valid;
  end

endmodule

// File: tb/tb_sin_cos_arb.sv
// Self-checking bench for sin_cos_arb: randomized stimulus against a queue-based reference model.
module tb_sin_cos_arb;
  localparam int WIDTH = 16, PHASE_W = 10, NREQ = 4, LAT = 2, ID_W = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    en;
  logic [NREQ-1:0]         req_valid, req_lock, req_ready;
  logic [NREQ*PHASE_W-1:0] req_phase;
  logic [PHASE_W-1:0]      core_phase;
  logic                    core_valid;
  logic [WIDTH-1:0]        core_sin, core_cos, rsp_sin, rsp_cos;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic                    busy;
  logic [PHASE_W-1:0]      d1 = '0, d2 = '0;

  sin_cos_arb #(.WIDTH(WIDTH), .PHASE_W(PHASE_W), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_phase(req_phase),
    .req_lock(req_lock), .req_ready(req_ready), .core_phase(core_phase), .core_valid(core_valid),
    .core_sin(core_sin), .core_cos(core_cos), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model: sin = zero-extended phase, cos = ~sin, two cycles after sampling.
  always @(posedge clk) begin
    d1 <= core_phase;
    d2 <= d1;
  end
  assign core_sin = WIDTH'(d2);
  assign core_cos = ~core_sin;

  typedef struct {int id; int phase; int due;} exp_t;
  exp_t q[$];
  int   grants[$];
  int   mptr = 0, cyc = 0, last_phase = 0;
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int winner();
    if (!en) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return -1;
  endfunction

  // One clock: check the grant, apply the model at the edge, check outputs at negedge.
  task automatic cycle();
    int   w, ph;
    bit   lk;
    exp_t e;
    #1;
    w  = winner();
    ph = (w >= 0) ? int'(req_phase[w*PHASE_W +: PHASE_W]) : 0;
    lk = (w >= 0) ? req_lock[w] : 1'b0;
    chk("req_ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
    @(posedge clk);
    cyc++;
    if (w >= 0) begin
      e.id = w; e.phase = ph; e.due = cyc + LAT + 1;
      q.push_back(e);
      grants.push_back(w);
      last_phase = ph;
`ifdef SIN_COS_ARB_LOCK_EN
      mptr = lk ? w : (w + 1) % NREQ;
`else
      mptr = (w + 1) % NREQ;
`endif
    end
    @(negedge clk);
    chk("core_valid", 32'(core_valid), 32'(w >= 0));
    chk("core_phase", 32'(core_phase), last_phase);
    chk("busy", 32'(busy), 32'(q.size() > 0));
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_id", 32'(rsp_id), e.id);
      chk("rsp_sin", 32'(rsp_sin), e.phase);
      chk("rsp_cos", 32'(rsp_cos), (~e.phase) & 32'hFFFF);
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 0);
    end
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) cycle();
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; req_valid = '0; req_lock = '0; req_phase = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_sin", 32'(rsp_sin), 0);
    chk("rst_rsp_cos", 32'(rsp_cos), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_core_valid", 32'(core_valid), 0);
    chk("rst_core_phase", 32'(core_phase), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    cycle();

    // All four continuously valid: strict rotation from 0.
    grants.delete();
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      req_phase = {$urandom, $urandom};
      cycle();
    end
    idle(4);
    chk("rr_count", grants.size(), 8);
    for (int k = 0; k < 8 && k < grants.size(); k++) chk("rr_order", grants[k], k % NREQ);

    // Single request from requester 2.
    req_valid = 4'b0100;
    req_phase = '0;
    req_phase[2*PHASE_W +: PHASE_W] = 10'h155;
    cycle();
    idle(4);

    // en drops after two grants; the in-flight pair still completes.
    req_valid = '1;
    repeat (2) begin req_phase = {$urandom, $urandom}; cycle(); end
    en = 1'b0;
    repeat (6) cycle();
    en = 1'b1;
    idle(1);

    // Async reset with two tags in flight.
    req_valid = '1;
    repeat (2) begin req_phase = {$urandom, $urandom}; cycle(); end
    req_valid = '0;
    #2 reset = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_core_valid", 32'(core_valid), 0);
    q.delete();
    mptr = 0; last_phase = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(5);
    req_valid = '1;
    req_phase = {$urandom, $urandom};
    cycle();
    idle(4);

    // Randomized traffic, enables and lock hints.
    for (int c = 0; c < 80; c++) begin
      en        = ($urandom_range(0, 7) != 0);
      req_valid = NREQ'($urandom);
      req_lock  = NREQ'($urandom);
      req_phase = {$urandom, $urandom};
      cycle();
    end
    en = 1'b1; req_lock = '0;
    idle(5);

`ifdef SIN_COS_ARB_LOCK_EN
    // Requester 1 holds priority while locked, then 3 wins.
    grants.delete();
    req_valid = 4'b1010;
    req_lock  = 4'b0010;
    repeat (4) begin req_phase = {$urandom, $urandom}; cycle(); end
    req_lock = '0;
    repeat (2) cycle();
    idle(4);
    for (int k = 0; k < 4 && k < grants.size(); k++) chk("lock_hold", grants[k], 1);
    if (grants.size() > 5) chk("lock_release", grants[5], 3);
    else chk("lock_grants", grants.size(), 6);
`endif

    chk("drain_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
